// File: rtl/rf_wb_pkg.sv
// Shared types and constants for the register-file write-back stage.
package rf_wb_pkg;

    localparam int WB_DATA_W = 16;
    localparam int WB_ADDR_W = 2;
    localparam int WB_BASE_W = 6;
    localparam int WB_DEPTH  = 2;

    typedef enum logic [1:0] {
        WP_NONE = 2'b00,
        WP_ADD  = 2'b01,
        WP_CLR  = 2'b10
    } wp_cmd_t;

    typedef struct packed {
        logic [WB_DATA_W-1:0] data;
        logic [WB_ADDR_W-1:0] addr;
        logic [1:0]           be;
        logic [WB_BASE_W-1:0] base;
    } wb_entry_t;

    // Physical register index: window base plus in-window index, modulo 64.
    function automatic logic [WB_BASE_W-1:0] phys_idx(
        input logic [WB_BASE_W-1:0] base,
        input logic [WB_ADDR_W-1:0] addr
    );
        return base + WB_BASE_W'(addr);
    endfunction

endpackage

// File: rtl/rf_wb_fifo.sv
// Shift-register FIFO of write-back entries; slot 0 is always the head.
module rf_wb_fifo
    import rf_wb_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             push,
    input  logic                             pop,
    input  wb_entry_t                        din,
    output wb_entry_t                        head,
    output wb_entry_t [DEPTH-1:0]            entries,
    output logic [$clog2(DEPTH+1)-1:0]       count,
    output logic                             full,
    output logic                             empty
);

    localparam int CW = $clog2(DEPTH+1);

    wb_entry_t [DEPTH-1:0] mem;
    wb_entry_t [DEPTH-1:0] mem_nxt;
    logic [CW-1:0]         count_nxt;
    logic [CW-1:0]         wr_idx;

    // On a simultaneous pop the new entry lands one slot lower, behind the shifted data.
    always_comb begin
        mem_nxt   = mem;
        wr_idx    = pop ? count - CW'(1) : count;
        count_nxt = count + CW'(push) - CW'(pop);
        if (pop) begin
            for (int unsigned k = 0; k + 1 < DEPTH; k++) begin
                mem_nxt[k] = mem[k+1];
            end
        end
        if (push) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                if (wr_idx == CW'(k)) begin
                    mem_nxt[k] = din;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem   <= '0;
            count <= '0;
        end else begin
            mem   <= mem_nxt;
            count <= count_nxt;
        end
    end

    assign head    = mem[0];
    assign entries = mem;
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);

endmodule

// File: rtl/rf_writeback.sv
// Write-back stage ahead of the Sayeh register file: arbitration, window pointer, drain.
// Optional hazard scoreboard on q_hit enabled by defining RF_WB_SCOREBOARD_EN.
module rf_writeback
    import rf_wb_pkg::*;
#(
    parameter int DATA_W = WB_DATA_W,
    parameter int ADDR_W = WB_ADDR_W,
    parameter int BASE_W = WB_BASE_W,
    parameter int DEPTH  = WB_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [DATA_W-1:0] alu_data,
    input  logic [ADDR_W-1:0] alu_addr,
    input  logic [1:0]        alu_be,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [DATA_W-1:0] mem_data,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [1:0]        mem_be,
    input  logic [1:0]        wp_cmd,
    input  logic [BASE_W-1:0] wp_imm,
    output logic [BASE_W-1:0] wp,
    output logic [DATA_W-1:0] rf_in,
    output logic [ADDR_W-1:0] rf_laddr,
    output logic [BASE_W-1:0] rf_base,
    output logic              rf_lwrite,
    output logic              rf_hwrite,
    output logic              busy,
    input  logic [ADDR_W-1:0] q_addr,
    output logic              q_hit
);

    localparam int CW = $clog2(DEPTH+1);

    wb_entry_t             in_entry;
    wb_entry_t             head;
    wb_entry_t [DEPTH-1:0] entries;
    logic [CW-1:0]         count;
    logic                  full;
    logic                  empty;
    logic                  take_mem;
    logic                  take_alu;
    logic                  push;
    logic                  pop;
    logic [BASE_W-1:0]     wp_nxt;

    always_comb begin
        mem_ready = rst_n && !full;
        alu_ready = rst_n && !full && !mem_valid;
        take_mem  = mem_valid && mem_ready;
        take_alu  = alu_valid && alu_ready;

        in_entry.data = take_mem ? mem_data : alu_data;
        in_entry.addr = take_mem ? mem_addr : alu_addr;
        in_entry.be   = take_mem ? mem_be   : alu_be;
        in_entry.base = wp;

        // Zero byte-enable transfers are acknowledged but never queued.
        push = (take_mem || take_alu) && (in_entry.be != '0);
        pop  = !empty;
    end

    always_comb begin
        wp_nxt = wp;
        case (wp_cmd_t'(wp_cmd))
            WP_ADD:  wp_nxt = wp + wp_imm;
            WP_CLR:  wp_nxt = '0;
            default: wp_nxt = wp;
        endcase
    end

    rf_wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push),
        .pop     (pop),
        .din     (in_entry),
        .head    (head),
        .entries (entries),
        .count   (count),
        .full    (full),
        .empty   (empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp        <= '0;
            rf_in     <= '0;
            rf_laddr  <= '0;
            rf_base   <= '0;
            rf_lwrite <= 1'b0;
            rf_hwrite <= 1'b0;
        end else begin
            wp <= wp_nxt;
            if (pop) begin
                rf_in     <= head.data;
                rf_laddr  <= head.addr;
                rf_base   <= head.base;
                rf_hwrite <= head.be[1];
                rf_lwrite <= head.be[0];
            end else begin
                rf_laddr  <= '0;
                rf_base   <= wp_nxt;
                rf_hwrite <= 1'b0;
                rf_lwrite <= 1'b0;
            end
        end
    end

    assign busy = !empty || rf_lwrite || rf_hwrite;

`ifdef RF_WB_SCOREBOARD_EN
    logic [BASE_W-1:0] target;

    // Queued entries plus the one on the strobes are all still in flight.
    always_comb begin
        target = phys_idx(wp, q_addr);
        q_hit  = (rf_lwrite || rf_hwrite) && (phys_idx(rf_base, rf_laddr) == target);
        for (int unsigned k = 0; k < DEPTH; k++) begin
            if ((CW'(k) < count) && (phys_idx(entries[k].base, entries[k].addr) == target)) begin
                q_hit = 1'b1;
            end
        end
    end
`else
    logic unused_sb;
    assign unused_sb = ^{q_addr, count, entries};
    assign q_hit     = 1'b0;
`endif

endmodule
